// File: rtl/ysyx_23060061_axil_pkg.sv
// Shared definitions for the AXI-Lite initiator.
//   RESP_*       AXI response codes carried on rresp/bresp and rsp_resp
//   state_t      transaction state of the initiator
//   *_W_DEF      default address/data widths
package ysyx_23060061_axil_pkg;

  localparam int unsigned ADDR_W_DEF = 32;
  localparam int unsigned DATA_W_DEF = 32;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  typedef enum logic [2:0] {
    IDLE,
    RD_ADDR,
    RD_DATA,
    WR_REQ,
    WR_RESP,
    RESP
  } state_t;

endpackage

// File: rtl/ysyx_23060061_axil_if.sv
// AXI-Lite bus bundle between the initiator (master) and a responder (slave).
//   AR/R : araddr, arvalid, arready, rdata, rresp, rvalid, rready
//   AW/W : awaddr, awvalid, awready, wdata, wstrb, wvalid, wready
//   B    : bresp, bvalid, bready
interface ysyx_23060061_axil_if #(
  parameter int unsigned ADDR_W = ysyx_23060061_axil_pkg::ADDR_W_DEF,
  parameter int unsigned DATA_W = ysyx_23060061_axil_pkg::DATA_W_DEF
);

  logic [ADDR_W-1:0]   araddr;
  logic                arvalid;
  logic                arready;
  logic [DATA_W-1:0]   rdata;
  logic [1:0]          rresp;
  logic                rvalid;
  logic                rready;

  logic [ADDR_W-1:0]   awaddr;
  logic                awvalid;
  logic                awready;
  logic [DATA_W-1:0]   wdata;
  logic [DATA_W/8-1:0] wstrb;
  logic                wvalid;
  logic                wready;

  logic [1:0]          bresp;
  logic                bvalid;
  logic                bready;

  modport master (
    output araddr, arvalid, input  arready,
    input  rdata, rresp, rvalid, output rready,
    output awaddr, awvalid, input  awready,
    output wdata, wstrb, wvalid, input  wready,
    input  bresp, bvalid, output bready
  );

  modport slave (
    input  araddr, arvalid, output arready,
    output rdata, rresp, rvalid, input  rready,
    input  awaddr, awvalid, output awready,
    input  wdata, wstrb, wvalid, output wready,
    output bresp, bvalid, input  bready
  );

endinterface

// File: rtl/ysyx_23060061_axil_master.sv
// AXI-Lite initiator for the core memory path. Takes one load/store request at a
// time, runs it on AR/R or AW/W/B, and returns a single-cycle response pulse.
// Strictly one outstanding transaction.
//   clk, rst     clock, synchronous active-high reset
//   req_*        request handshake (valid/ready) with wen, addr, wdata, wmask
//   rsp_valid    one-cycle completion pulse; rsp_rdata (loads) and rsp_resp
//   axi          AXI-Lite master port
module ysyx_23060061_axil_master
  import ysyx_23060061_axil_pkg::*;
#(
  parameter int unsigned ADDR_W = ADDR_W_DEF,
  parameter int unsigned DATA_W = DATA_W_DEF
) (
  input  logic                clk,
  input  logic                rst,

  input  logic                req_valid,
  output logic                req_ready,
  input  logic                req_wen,
  input  logic [ADDR_W-1:0]   req_addr,
  input  logic [DATA_W-1:0]   req_wdata,
  input  logic [DATA_W/8-1:0] req_wmask,

  output logic                rsp_valid,
  output logic [DATA_W-1:0]   rsp_rdata,
  output logic [1:0]          rsp_resp,

  ysyx_23060061_axil_if.master axi
);

  state_t                state;

  logic [ADDR_W-1:0]     addr_q;
  logic [DATA_W-1:0]     wdata_q;
  logic [DATA_W/8-1:0]   wmask_q;

  logic                  arvalid;
  logic                  rready;
  logic                  awvalid;
  logic                  wvalid;
  logic                  bready;

  // AW and W may complete in either order or together.
  logic                  aw_done;
  logic                  w_done;

  logic                  aw_hs;
  logic                  w_hs;
  logic                  aw_fin;
  logic                  w_fin;

  // Payloads come straight from the request latches, so they stay stable
  // for as long as the corresponding valid is held.
  assign axi.araddr  = addr_q;
  assign axi.arvalid = arvalid;
  assign axi.rready  = rready;
  assign axi.awaddr  = addr_q;
  assign axi.awvalid = awvalid;
  assign axi.wdata   = wdata_q;
  assign axi.wstrb   = wmask_q;
  assign axi.wvalid  = wvalid;
  assign axi.bready  = bready;

  assign aw_hs  = awvalid && axi.awready;
  assign w_hs   = wvalid && axi.wready;
  // Include the handshakes of the current cycle so the finishing cycle
  // already moves on to B.
  assign aw_fin = aw_done || aw_hs;
  assign w_fin  = w_done || w_hs;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      req_ready <= 1'b1;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_resp  <= '0;
      addr_q    <= '0;
      wdata_q   <= '0;
      wmask_q   <= '0;
      arvalid   <= 1'b0;
      rready    <= 1'b0;
      awvalid   <= 1'b0;
      wvalid    <= 1'b0;
      bready    <= 1'b0;
      aw_done   <= 1'b0;
      w_done    <= 1'b0;
    end else begin
      rsp_valid <= 1'b0;
      unique case (state)
        IDLE: begin
          if (req_valid && req_ready) begin
            addr_q    <= req_addr;
            wdata_q   <= req_wdata;
            wmask_q   <= req_wmask;
            req_ready <= 1'b0;
            if (req_wen) begin
              awvalid <= 1'b1;
              wvalid  <= 1'b1;
              aw_done <= 1'b0;
              w_done  <= 1'b0;
              state   <= WR_REQ;
            end else begin
              arvalid <= 1'b1;
              state   <= RD_ADDR;
            end
          end
        end

        RD_ADDR: begin
          if (axi.arready) begin
            arvalid <= 1'b0;
            rready  <= 1'b1;
            state   <= RD_DATA;
          end
        end

        RD_DATA: begin
          if (axi.rvalid) begin
            rsp_rdata <= axi.rdata;
            rsp_resp  <= axi.rresp;
            rready    <= 1'b0;
            rsp_valid <= 1'b1;
            state     <= RESP;
          end
        end

        WR_REQ: begin
          if (aw_hs) begin
            awvalid <= 1'b0;
            aw_done <= 1'b1;
          end
          if (w_hs) begin
            wvalid <= 1'b0;
            w_done <= 1'b1;
          end
          if (aw_fin && w_fin) begin
            aw_done <= 1'b0;
            w_done  <= 1'b0;
            bready  <= 1'b1;
            state   <= WR_RESP;
          end
        end

        WR_RESP: begin
          if (axi.bvalid) begin
            rsp_resp  <= axi.bresp;
            bready    <= 1'b0;
            rsp_valid <= 1'b1;
            state     <= RESP;
          end
        end

        RESP: begin
          req_ready <= 1'b1;
          state     <= IDLE;
        end

        default: begin
          state     <= IDLE;
          req_ready <= 1'b1;
        end
      endcase
    end
  end

endmodule
